// File: rtl/buffer_pair_reader.sv
// Read-side sequencer for a dual-read-port register buffer: walks the buffer, registers operand pairs
// and streams them over valid/ready. Optional continuous mode: BUFFER_PAIR_READER_CONT_EN.
module buffer_pair_reader #(
   parameter int DataWidth   = 8,
   parameter int BufferSize  = 4,
   parameter int BufferWidth = 2
) (
   input  logic                   clk,
   input  logic                   aclr,
   input  logic                   clk_en,
   input  logic                   start,
`ifdef BUFFER_PAIR_READER_CONT_EN
   input  logic                   stop,
`endif
   input  logic [BufferWidth:0]   count,
   input  logic [BufferWidth-1:0] offset,
   output logic [BufferWidth-1:0] R_Addr1,
   output logic [BufferWidth-1:0] R_Addr2,
   input  logic [DataWidth-1:0]   DataIn1,
   input  logic [DataWidth-1:0]   DataIn2,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DataWidth-1:0]   out_data1,
   output logic [DataWidth-1:0]   out_data2,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   localparam logic [BufferWidth-1:0] LastIdx = BufferWidth'(BufferSize - 1);
   localparam logic [BufferWidth:0]   SizeExt = (BufferWidth + 1)'(BufferSize);

   state_t                 state_q, state_d;
   logic [BufferWidth-1:0] ptr_q, ptr_d;
   logic [BufferWidth-1:0] addr2_q, addr2_d;
   logic [BufferWidth:0]   issued_q, issued_d;
   logic [BufferWidth:0]   len_q, len_d;
   logic [BufferWidth-1:0] offset_q, offset_d;
   logic                   valid_q, valid_d;
   logic [DataWidth-1:0]   data1_q, data1_d;
   logic [DataWidth-1:0]   data2_q, data2_d;
   logic                   done_q, done_d;

   logic                   load;
   logic                   xfer;
   logic                   last;
   logic                   exit_run;
   logic [BufferWidth-1:0] ptr_inc;
   logic [BufferWidth:0]   issued_nxt;

   // Modular add of two in-range indices; operands are both < BufferSize.
   function automatic logic [BufferWidth-1:0] wrap_add(input logic [BufferWidth-1:0] a,
                                                       input logic [BufferWidth-1:0] b);
      logic [BufferWidth:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= SizeExt) s = s - SizeExt;
      return s[BufferWidth-1:0];
   endfunction

   assign load    = (state_q == S_RUN) && (!valid_q || out_ready);
   assign xfer    = valid_q && out_ready;
   assign last    = (issued_q == (len_q - 1'b1));
   assign ptr_inc = (ptr_q == LastIdx) ? '0 : ptr_q + 1'b1;

`ifdef BUFFER_PAIR_READER_CONT_EN
   assign exit_run   = stop;
   assign issued_nxt = last ? '0 : issued_q + 1'b1;
`else
   assign exit_run   = last;
   assign issued_nxt = issued_q + 1'b1;
`endif

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         addr2_q  <= '0;
         issued_q <= '0;
         len_q    <= '0;
         offset_q <= '0;
         valid_q  <= 1'b0;
         data1_q  <= '0;
         data2_q  <= '0;
         done_q   <= 1'b0;
      end else if (clk_en) begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         addr2_q  <= addr2_d;
         issued_q <= issued_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         valid_q  <= valid_d;
         data1_q  <= data1_d;
         data2_q  <= data2_d;
         done_q   <= done_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && (count != '0)) state_d = S_RUN;
         S_RUN:   if (load && exit_run) state_d = S_DRAIN;
         S_DRAIN: if (xfer) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : datapath
      ptr_d    = ptr_q;
      addr2_d  = addr2_q;
      issued_d = issued_q;
      len_d    = len_q;
      offset_d = offset_q;
      valid_d  = valid_q;
      data1_d  = data1_q;
      data2_d  = data2_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  len_d    = count;
                  offset_d = offset;
                  ptr_d    = '0;
                  addr2_d  = wrap_add('0, offset);
                  issued_d = '0;
               end
            end
         end
         S_RUN: begin
            // Addresses advance with the load so the next pair is already presented by the buffer.
            if (load) begin
               data1_d  = DataIn1;
               data2_d  = DataIn2;
               valid_d  = 1'b1;
               issued_d = issued_nxt;
               ptr_d    = ptr_inc;
               addr2_d  = wrap_add(ptr_inc, offset_q);
            end
         end
         S_DRAIN: begin
            if (xfer) begin
               valid_d = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin : outputs
      R_Addr1   = ptr_q;
      R_Addr2   = addr2_q;
      out_valid = valid_q;
      out_data1 = data1_q;
      out_data2 = data2_q;
      busy      = (state_q != S_IDLE);
      done      = done_q;
   end

endmodule

// File: tb/tb_buffer_pair_reader.sv
// Bench for buffer_pair_reader: command table plus scoreboard of expected operand pairs.
`timescale 1ns/1ps
module tb_buffer_pair_reader;
   localparam int DW = 8;
   localparam int BS = 4;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          aclr, clk_en, start, out_ready;
   logic [BW:0]   count;
   logic [BW-1:0] offset;
   logic [BW-1:0] R_Addr1, R_Addr2;
   logic [DW-1:0] DataIn1, DataIn2, out_data1, out_data2;
   logic          out_valid, busy, done;
`ifdef BUFFER_PAIR_READER_CONT_EN
   logic          stop = 1'b0;
`endif

   logic [DW-1:0] mem [BS];
   assign DataIn1 = mem[R_Addr1];
   assign DataIn2 = mem[R_Addr2];

   always #5 clk = ~clk;

   buffer_pair_reader #(.DataWidth(DW), .BufferSize(BS), .BufferWidth(BW)) dut (
      .clk(clk), .aclr(aclr), .clk_en(clk_en), .start(start),
`ifdef BUFFER_PAIR_READER_CONT_EN
      .stop(stop),
`endif
      .count(count), .offset(offset), .R_Addr1(R_Addr1), .R_Addr2(R_Addr2),
      .DataIn1(DataIn1), .DataIn2(DataIn2), .out_valid(out_valid), .out_ready(out_ready),
      .out_data1(out_data1), .out_data2(out_data2), .busy(busy), .done(done)
   );

   typedef struct {
      string       name;
      int          cnt;
      int          off;
      logic [63:0] stall;
      logic [63:0] frz;
      int          restart;
      int          chk_addr;
      int          exp_pairs;
      int          exp_done;
   } cmd_t;

   typedef struct {
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
   } pair_t;

   pair_t sbq[$];
   int    passed = 0;
   int    total  = 0;
   cmd_t  tbl[7];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic check_cleared(input string nm);
      check({nm, ".addr1"}, 32'(R_Addr1), 0);
      check({nm, ".addr2"}, 32'(R_Addr2), 0);
      check({nm, ".valid"}, 32'(out_valid), 0);
      check({nm, ".data1"}, 32'(out_data1), 0);
      check({nm, ".data2"}, 32'(out_data2), 0);
      check({nm, ".busy"}, 32'(busy), 0);
      check({nm, ".done"}, 32'(done), 0);
   endtask

   task automatic run_cmd(input cmd_t c);
      int    done_cyc = -1;
      int    xfers = 0;
      int    busy_cyc = 0;
      logic  prev_hold = 1'b0;
      logic [31:0] pa1 = 0, pa2 = 0, pv = 0, pd1 = 0, pd2 = 0, pb = 0;
      pair_t p;
      @(negedge clk);
      start = 1'b1; count = 3'(c.cnt); offset = 2'(c.off); out_ready = 1'b1; clk_en = 1'b1;
      for (int i = 0; i < c.cnt; i++)
         sbq.push_back('{mem[i % BS], mem[(i + c.off) % BS]});
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         // Inputs changed after start must not disturb the latched command.
         start     = (cyc == c.restart);
         count     = 3'd1;
         offset    = 2'd0;
         out_ready = !c.stall[cyc];
         clk_en    = !c.frz[cyc];
         if (prev_hold) begin
            check($sformatf("%s.hold_addr1@%0d", c.name, cyc), 32'(R_Addr1), pa1);
            check($sformatf("%s.hold_addr2@%0d", c.name, cyc), 32'(R_Addr2), pa2);
            check($sformatf("%s.hold_valid@%0d", c.name, cyc), 32'(out_valid), pv);
            check($sformatf("%s.hold_data1@%0d", c.name, cyc), 32'(out_data1), pd1);
            check($sformatf("%s.hold_data2@%0d", c.name, cyc), 32'(out_data2), pd2);
            check($sformatf("%s.hold_busy@%0d", c.name, cyc), 32'(busy), pb);
         end
         if (c.chk_addr != 0 && cyc <= c.cnt) begin
            check($sformatf("%s.addr1@%0d", c.name, cyc), 32'(R_Addr1), (cyc - 1) % BS);
            check($sformatf("%s.addr2@%0d", c.name, cyc), 32'(R_Addr2), (cyc - 1 + c.off) % BS);
         end
         if (busy) busy_cyc++;
         if (out_valid && out_ready && clk_en) begin
            xfers++;
            if (sbq.size() == 0) begin
               check($sformatf("%s.extra_pair@%0d", c.name, cyc), 1, 0);
            end else begin
               p = sbq.pop_front();
               check($sformatf("%s.data1@%0d", c.name, cyc), 32'(out_data1), 32'(p.d1));
               check($sformatf("%s.data2@%0d", c.name, cyc), 32'(out_data2), 32'(p.d2));
            end
         end
         if (done && done_cyc < 0) begin
            done_cyc = cyc;
            check($sformatf("%s.busy_at_done", c.name), 32'(busy), 0);
         end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
            check($sformatf("%s.done_width", c.name), 32'(done), 0);
            break;
         end
         prev_hold = !clk_en || (out_valid && !out_ready);
         pa1 = 32'(R_Addr1); pa2 = 32'(R_Addr2); pv = 32'(out_valid);
         pd1 = 32'(out_data1); pd2 = 32'(out_data2); pb = 32'(busy);
      end
      check({c.name, ".done_cycle"}, 32'(done_cyc), 32'(c.exp_done));
      check({c.name, ".pairs"}, 32'(xfers), 32'(c.exp_pairs));
      check({c.name, ".busy_cycles"}, 32'(busy_cyc), 32'(c.exp_done - 1));
      check({c.name, ".sb_empty"}, 32'(sbq.size()), 0);
      sbq.delete();
      start = 1'b0; clk_en = 1'b1; out_ready = 1'b1;
   endtask

   initial begin
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      // name, count, offset, stall mask, freeze mask, restart cycle, check addrs, pairs, done cycle
      tbl[0] = '{"basic_off1",   4, 1, 64'h0,  64'h0,  0, 1, 4, 6};
      tbl[1] = '{"stall_off2",   4, 2, 64'h18, 64'h0,  0, 0, 4, 8};
      tbl[2] = '{"count_zero",   0, 1, 64'h0,  64'h0,  0, 0, 0, 1};
      tbl[3] = '{"wrap_off3",    6, 3, 64'h0,  64'h0,  0, 1, 6, 8};
      tbl[4] = '{"freeze",       4, 1, 64'h0,  64'h38, 0, 0, 4, 9};
      tbl[5] = '{"single_off3",  1, 3, 64'h0,  64'h0,  0, 1, 1, 3};
      tbl[6] = '{"restart_busy", 3, 2, 64'h0,  64'h0,  2, 1, 3, 5};

      aclr = 1'b1; clk_en = 1'b1; start = 1'b0; out_ready = 1'b1; count = '0; offset = '0;
      #12;
      check_cleared("reset");
      @(negedge clk);
      aclr = 1'b0;

      for (int t = 0; t < 6; t++) run_cmd(tbl[t]);

      // Abort mid-run after two transfers.
      @(negedge clk);
      start = 1'b1; count = 3'd4; offset = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort.pre_valid", 32'(out_valid), 1);
      check("abort.pre_data1", 32'(out_data1), 32'h33);
      check("abort.pre_data2", 32'(out_data2), 32'h44);
      check("abort.pre_addr1", 32'(R_Addr1), 3);
      aclr = 1'b1;
      #1;
      check_cleared("abort");
      @(negedge clk);
      aclr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("abort.no_done@%0d", k), 32'(done), 0);
         check($sformatf("abort.idle_valid@%0d", k), 32'(out_valid), 0);
         check($sformatf("abort.idle_busy@%0d", k), 32'(busy), 0);
      end

      run_cmd(tbl[6]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/buffer_pair_reader.md
Name: buffer_pair_reader

Overview:
- Read-side sequencer for the dual-read-port register buffer in the convolution datapath.
- On a start command it walks the buffer and drives the buffer's two read addresses, with address 2 a fixed offset ahead of address 1.
- It registers each returned operand pair and streams the pairs to the MAC stage over a valid/ready handshake.
- Throughput is one pair per cycle when the consumer does not stall.

Parameters:
- DataWidth, 8, width of each buffer entry and each output operand.
- BufferSize, 4, number of buffer entries; any value >= 2, not required to be a power of two.
- BufferWidth, 2, address width; ceil(log2(BufferSize)).

Ports:
- clk  in  1  clock, rising edge.
- aclr  in  1  asynchronous, active-high reset.
- clk_en  in  1  global enable; when low, all state is frozen.
- start  in  1  command strobe; sampled only in IDLE.
- count  in  BufferWidth+1  number of pairs to read; latched at start.
- offset  in  BufferWidth  distance from addr1 to addr2; latched at start; must be < BufferSize.
- R_Addr1  out  BufferWidth  read address 1 to the buffer.
- R_Addr2  out  BufferWidth  read address 2 to the buffer.
- DataIn1  in  DataWidth  buffer read data for R_Addr1 (combinational read).
- DataIn2  in  DataWidth  buffer read data for R_Addr2 (combinational read).
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer ready.
- out_data1  out  DataWidth  registered operand 1.
- out_data2  out  DataWidth  registered operand 2.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (aclr high, asynchronous): state=IDLE; ptr, issued, len and offset registers = 0; R_Addr1=R_Addr2=0; out_valid=0; out_data1=out_data2=0; busy=0; done=0.
- clk_en low: no register changes. A transfer happens only on an edge where clk_en=1, out_valid=1 and out_ready=1.
- done is registered. It defaults to 0 every enabled cycle unless set below.
- Address generation:
  - R_Addr1 = ptr.
  - R_Addr2 = ptr+offset; if the sum is >= BufferSize, subtract BufferSize.
  - Both are registered outputs that track ptr.
- IDLE:
  - start=1 with count=0: done=1 next cycle, remain in IDLE.
  - start=1 with count>0: len=count, offset latched, ptr=0, issued=0, go to RUN.
- RUN:
  - load = !out_valid || out_ready.
  - On load:
    - out_data1/2 <= DataIn1/2, out_valid <= 1, issued+1.
    - ptr+1, wrapping from BufferSize-1 to 0.
    - If issued == len-1: go to DRAIN.
  - Without load: hold all state.
- DRAIN: on a transfer, out_valid <= 0, done <= 1, go to IDLE.
- Latency, with no stalls:
  - start sampled at edge 0; RUN from cycle 1; first pair valid from cycle 2.
  - Last pair valid at cycle len+1.
  - done is high during the cycle after the final transfer edge.
- count > BufferSize is legal: ptr wraps and entries are re-read in order.
- start while busy=1 is ignored; latched count and offset are unchanged.
- aclr mid-operation aborts immediately. No done pulse; any pending pair is discarded.
- Buffer writes during RUN are the system's responsibility. The reader samples whatever the buffer presents on the load edge.

Optional Feature:
- Macro: BUFFER_PAIR_READER_CONT_EN.
- Defined:
  - Adds input stop (1 bit).
  - In RUN, reaching issued == len-1 resets issued to 0 and continues wrapping instead of entering DRAIN.
  - The exit to DRAIN is taken on the load edge where stop=1 is sampled, after that pair is loaded.
  - count=0 still completes immediately.
- Not defined: no stop port; behaviour exactly as above.

Test Plan:
1. Buffer=[0x11,0x22,0x33,0x44], count=4, offset=1, out_ready=1 -> pairs (11,22),(22,33),(33,44),(44,11) on cycles 2-5; done high cycle 6; busy low cycle 6.
2. Same buffer, offset=2, out_ready low on cycles 3-4 -> pair (22,44) held stable with out_valid=1 through the stall; all 4 pairs delivered, none duplicated or dropped; done one cycle after the last transfer.
3. count=0, start=1 -> no out_valid; done high for exactly 1 cycle; busy stays 0.
4. count=6, offset=3 -> R_Addr1 sequence 0,1,2,3,0,1; R_Addr2 sequence 3,0,1,2,3,0; 6 pairs delivered.
5. clk_en low on cycles 3-5 with out_ready=1 -> outputs and addresses frozen; no transfer counted; resumes with the correct next pair.
6. aclr pulsed mid-RUN after 2 transfers, then start is pulsed with start=1 while busy in a new command -> outputs zero, state IDLE, no done; second start ignored; new command runs from ptr=0.
